alu_result_stage: RTL

- Downstream neighbour of the ALU: captures each ALU result (16-bit out, 3-bit flags Z) under a valid/ready handshake.
- Loads the status register on compare operations.
- Buffers register writebacks in a small FIFO so the ALU is not stalled by a busy register-file write port.
- Drains one writeback per cycle toward the register file.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/alu_result_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: ALUop encodings, flag bit indices,
// writeback entry layout and the writeback FIFO fill states.
package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_REG_W  = 3;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [ALU_REG_W-1:0]  reg_idx;
  } wb_entry_t;

  // Fill state of the writeback FIFO, derived from its occupancy count.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: DEPTH entries, pointers wrap by compare so DEPTH need not be a
// power of two. o_state exposes the EMPTY/PARTIAL/FULL fill state.
module wb_fifo
  import alu_pkg::*;
#(
  parameter int W     = ALU_DATA_W + ALU_REG_W,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output fifo_state_t   o_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  fifo_state_t      w_state;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push = i_push && (w_state != FIFO_FULL);
  assign w_pop  = i_pop  && (w_state != FIFO_EMPTY);

  always_comb begin
    w_count_nxt = r_count;
    w_state     = FIFO_PARTIAL;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    if (r_count == '0)
      w_state = FIFO_EMPTY;
    else if (r_count == CNT_W'(DEPTH))
      w_state = FIFO_FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_state = w_state;

endmodule

// File: rtl/alu_result_stage.sv
// Captures ALU results, loads the status register on CMP and queues register
// writebacks. Optional performance counters are enabled by ALU_RESULT_PERF_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int REG_W  = ALU_REG_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_z,
  input  logic [1:0]        alu_op,
  input  logic              load_status,
  input  logic              wr_req,
  input  logic [REG_W-1:0]  dest_reg,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_reg,
  output logic [2:0]        status,
  output logic              status_err,
  output logic [15:0]       wb_count,
  output logic [15:0]       stall_count
);

  // Handshakes: a transfer happens on a clock edge where valid && ready; the
  // producer holds its payload while valid && !ready. in_ready depends only on
  // registered occupancy, never on wb_ready.

  fifo_state_t               w_fifo_state;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_cmp_legal;
  logic [DATA_W+REG_W-1:0]   w_head;
  logic [2:0]                r_status;
  logic                      r_status_err;

  assign in_ready    = (w_fifo_state != FIFO_FULL);
  assign wb_valid    = (w_fifo_state != FIFO_EMPTY);
  assign w_accept    = in_valid && in_ready;
  assign w_push      = w_accept && wr_req;
  assign w_pop       = wb_valid && wb_ready;
  assign w_cmp_legal = (alu_op == ALU_SUB);

  wb_fifo #(
    .W     (DATA_W + REG_W),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({alu_out, dest_reg}),
    .o_dout  (w_head),
    .o_state (w_fifo_state)
  );

  assign wb_data = w_head[DATA_W+REG_W-1:REG_W];
  assign wb_reg  = w_head[REG_W-1:0];

  // Flags are only meaningful for SUB; any other op must leave status untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status     <= 3'b000;
      r_status_err <= 1'b0;
    end else begin
      if (w_accept && load_status && w_cmp_legal) r_status <= alu_z;
      r_status_err <= w_accept && load_status && !w_cmp_legal;
    end
  end

  assign status     = r_status;
  assign status_err = r_status_err;

`ifdef ALU_RESULT_PERF_EN
  logic [15:0] r_wb_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop && (r_wb_count != 16'hFFFF)) r_wb_count <= r_wb_count + 1'b1;
      if (in_valid && !in_ready && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign wb_count    = r_wb_count;
  assign stall_count = r_stall_count;
`else
  assign wb_count    = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule
